// File: rtl/tqvp_bus_initiator.sv
// rtl/tqvp_bus_initiator.sv - Host end of the TinyQV peripheral data port (optional read timeout: TQVP_BUS_INIT_TIMEOUT_EN)
module tqvp_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [5:0]  address,
    output logic [31:0] data_in,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_out,
    input  logic        data_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RESP
    } state_t;

    localparam logic [1:0] SIZE_IDLE = 2'b11;

    // A zero limit would make every read an immediate error; reject it at elaboration.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t      state_q;
    logic [1:0]  size_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [5:0]  address_q;
    logic [31:0] data_in_q;
    logic [1:0]  data_write_n_q;
    logic [1:0]  data_read_n_q;
    logic [31:0] rdata_d;

`ifdef TQVP_BUS_INIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt_q;
`endif

    // Zero-extend peripheral read data to the width of the latched access size.
    always_comb begin
        rdata_d = data_out;
        case (size_q)
            2'b00:   rdata_d = {24'd0, data_out[7:0]};
            2'b01:   rdata_d = {16'd0, data_out[15:0]};
            default: rdata_d = data_out;
        endcase
    end

    // Transaction FSM; every port-facing output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            size_q         <= 2'b00;
            cmd_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= 1'b0;
            address_q      <= '0;
            data_in_q      <= '0;
            data_write_n_q <= SIZE_IDLE;
            data_read_n_q  <= SIZE_IDLE;
`ifdef TQVP_BUS_INIT_TIMEOUT_EN
            wait_cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        size_q      <= cmd_size;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        if (cmd_size == SIZE_IDLE) begin
                            // Illegal size: answer with an error, leave the bus untouched.
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            address_q <= cmd_addr;
                            data_in_q <= cmd_wdata;
                            if (cmd_write) begin
                                data_write_n_q <= cmd_size;
                                state_q        <= S_WR;
                            end else begin
                                data_read_n_q <= cmd_size;
                                state_q       <= S_RD;
`ifdef TQVP_BUS_INIT_TIMEOUT_EN
                                wait_cnt_q    <= '0;
`endif
                            end
                        end
                    end
                end
                S_WR: begin
                    data_write_n_q <= SIZE_IDLE;
                    rsp_valid_q    <= 1'b1;
                    state_q        <= S_RESP;
                end
                S_RD: begin
                    if (data_ready) begin
                        rsp_rdata_q   <= rdata_d;
                        data_read_n_q <= SIZE_IDLE;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= S_RESP;
`ifdef TQVP_BUS_INIT_TIMEOUT_EN
                    end else if (wait_cnt_q == CNT_LAST) begin
                        // Last permitted wait cycle passed without data_ready.
                        data_read_n_q <= SIZE_IDLE;
                        rsp_err_q     <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
`endif
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign address      = address_q;
    assign data_in      = data_in_q;
    assign data_write_n = data_write_n_q;
    assign data_read_n  = data_read_n_q;

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// tb/tb_tqvp_bus_initiator.sv - Self-checking bench for tqvp_bus_initiator
module tb_tqvp_bus_initiator;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_size;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;

    int passed;
    int total;

    tqvp_bus_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .address(address), .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        int bits;
        bits = 8 << sz;
        return (bits >= 32) ? 32'hFFFF_FFFF : ((32'h1 << bits) - 32'h1);
    endfunction

    // One command from handshake to response acceptance; starts in a cycle with cmd_ready expected high.
    task automatic run_txn(input bit wr, input logic [1:0] sz, input logic [5:0] ad,
                           input logic [31:0] wd, input logic [31:0] dout,
                           input int delay, input int hold);
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          strobes;
        exp_err   = (sz == 2'b11);
        exp_rdata = 32'h0;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz; cmd_addr = ad; cmd_wdata = wd;
        data_out = dout; data_ready = 1'b0;
        next();
        cmd_valid = 1'b0; cmd_write = $urandom_range(0, 1); cmd_size = 2'($urandom);
        cmd_addr = 6'($urandom); cmd_wdata = $urandom;
        chk("cmd_ready_busy", 32'(cmd_ready), 32'h0);
        if (exp_err) begin
            chk("ill_write_n", 32'(data_write_n), 32'h3);
            chk("ill_read_n", 32'(data_read_n), 32'h3);
        end else if (wr) begin
            chk("wr_strobe", 32'(data_write_n), 32'(sz));
            chk("wr_read_n", 32'(data_read_n), 32'h3);
            chk("wr_address", 32'(address), 32'(ad));
            chk("wr_data_in", data_in, wd);
            chk("wr_rsp_early", 32'(rsp_valid), 32'h0);
            next();
            chk("wr_strobe_off", 32'(data_write_n), 32'h3);
        end else begin
            strobes = delay + 1;
`ifdef TQVP_BUS_INIT_TIMEOUT_EN
            if (delay >= TO) begin
                strobes = TO;
                exp_err = 1'b1;
            end
`endif
            if (!exp_err) exp_rdata = dout & size_mask(sz);
            for (int k = 0; k < strobes; k++) begin
                data_ready = (k == delay);
                chk("rd_strobe", 32'(data_read_n), 32'(sz));
                chk("rd_write_n", 32'(data_write_n), 32'h3);
                chk("rd_rsp_early", 32'(rsp_valid), 32'h0);
                next();
            end
            data_ready = 1'b0;
            chk("rd_address", 32'(address), 32'(ad));
            chk("rd_strobe_off", 32'(data_read_n), 32'h3);
        end
        for (int h = 0; h <= hold; h++) begin
            rsp_ready = (h == hold);
            chk("rsp_valid", 32'(rsp_valid), 32'h1);
            chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("cmd_ready_resp", 32'(cmd_ready), 32'h0);
            next();
        end
        rsp_ready = 1'b0;
        chk("rsp_valid_done", 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        passed = 0; total = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'b00; cmd_addr = '0;
        cmd_wdata = '0; rsp_ready = 1'b0; data_out = '0; data_ready = 1'b0;
        next();
        next();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_address", 32'(address), 32'h0);
        chk("rst_data_in", data_in, 32'h0);
        chk("rst_write_n", 32'(data_write_n), 32'h3);
        chk("rst_read_n", 32'(data_read_n), 32'h3);
        rst = 1'b0;
        next();

        run_txn(1'b1, 2'b10, 6'h18, 32'h0300_00A5, 32'h0, 0, 0);
        run_txn(1'b0, 2'b00, 6'h19, 32'h0, 32'hFFFF_FF3C, 0, 0);
        run_txn(1'b0, 2'b01, 6'h05, 32'h0, 32'hABCD_1234, 5, 1);
        run_txn(1'b0, 2'b10, 6'h3F, 32'h0, 32'hDEAD_BEEF, 2, 0);
        run_txn(1'b1, 2'b11, 6'h01, 32'h1234_5678, 32'h0, 0, 0);
        run_txn(1'b0, 2'b00, 6'h02, 32'h0, 32'h0000_0081, 1, 10);
`ifdef TQVP_BUS_INIT_TIMEOUT_EN
        run_txn(1'b0, 2'b10, 6'h07, 32'h0, 32'h5555_AAAA, TO, 0);
        run_txn(1'b0, 2'b10, 6'h07, 32'h0, 32'h5555_AAAA, TO - 1, 0);
`endif

        // Reset while waiting for data_ready.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'b01; cmd_addr = 6'h0A;
        next();
        cmd_valid = 1'b0;
        chk("mid_rd_strobe", 32'(data_read_n), 32'h1);
        next();
        rst = 1'b1;
        next();
        chk("mid_rst_read_n", 32'(data_read_n), 32'h3);
        chk("mid_rst_write_n", 32'(data_write_n), 32'h3);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'h0);
        rst = 1'b0;
        next();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);

        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 6'($urandom),
                    $urandom, $urandom, $urandom_range(0, 6), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
